// File: rtl/booth_digit_serializer_if.sv
// Weight-in / Booth-digit-out handshake bundle for booth_digit_serializer.
// master = producer of weights and consumer of digit beats; slave = the serializer.
interface booth_digit_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int SW = $clog2(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_weight;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            out_sel;
  logic [SW-1:0]         out_shift;
  logic                  out_last;

  modport master (
    output in_valid, in_weight, out_ready,
    input  in_ready, out_valid, out_sel, out_shift, out_last
  );

  modport slave (
    input  in_valid, in_weight, out_ready,
    output in_ready, out_valid, out_sel, out_shift, out_last
  );
endinterface

// File: rtl/booth_digit_serializer.sv
// Recodes a signed weight into radix-2 Booth digits, one registered beat per cycle (first beat 1 cycle after accept).
// Beats hold stable while out_ready is low; in_ready = idle or last beat leaving, so weights stream without bubbles.
module booth_digit_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit SKIP_ZERO  = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  booth_digit_serializer_if.slave bus
);
  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] weight;
  logic [DATA_WIDTH-1:0] mask;
  logic                  out_valid_q;
  logic [1:0]            out_sel_q;
  logic [SW-1:0]         out_shift_q;
  logic                  out_last_q;

  logic                  accept;
  logic                  fire;
  logic [DATA_WIDTH-1:0] nz_digits;
  logic [DATA_WIDTH-1:0] load_mask;
  logic [DATA_WIDTH-1:0] nxt_mask;
  logic [DATA_WIDTH-1:0] nxt_weight;
  logic [DATA_WIDTH:0]   wx;
  logic [1:0]            nxt_sel;
  logic [SW-1:0]         nxt_shift;
  logic                  nxt_last;

  assign bus.in_ready  = (state == IDLE) | (out_valid_q & bus.out_ready & out_last_q);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_shift = out_shift_q;
  assign bus.out_last  = out_last_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign fire   = out_valid_q & bus.out_ready;

  // Digit i is nonzero exactly where weight bit i differs from bit i-1.
  assign nz_digits = bus.in_weight ^ {bus.in_weight[DATA_WIDTH-2:0], 1'b0};

  always_comb begin
    load_mask = SKIP_ZERO ? nz_digits : '1;
    // A zero weight still owes one (zero) beat at shift 0.
    if (load_mask == '0) load_mask = DATA_WIDTH'(1);
  end

  // Next beat: lowest pending position of the mask that will be live next cycle.
  always_comb begin
    nxt_mask   = accept ? load_mask : (mask & (mask - DATA_WIDTH'(1)));
    nxt_weight = accept ? bus.in_weight : weight;
    wx         = {nxt_weight, 1'b0};
    nxt_sel    = 2'b00;
    nxt_shift  = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (nxt_mask[i]) begin
        nxt_shift = SW'(i);
        nxt_sel   = {wx[i+1] & ~wx[i], wx[i] & ~wx[i+1]};
      end
    end
    nxt_last = ((nxt_mask & (nxt_mask - DATA_WIDTH'(1))) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      weight      <= '0;
      mask        <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= 2'b00;
      out_shift_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= EMIT;
            weight      <= nxt_weight;
            mask        <= nxt_mask;
            out_valid_q <= 1'b1;
            out_sel_q   <= nxt_sel;
            out_shift_q <= nxt_shift;
            out_last_q  <= nxt_last;
          end
        end
        EMIT: begin
          if (accept || (fire && !out_last_q)) begin
            weight      <= nxt_weight;
            mask        <= nxt_mask;
            out_valid_q <= 1'b1;
            out_sel_q   <= nxt_sel;
            out_shift_q <= nxt_shift;
            out_last_q  <= nxt_last;
          end else if (fire) begin
            state       <= IDLE;
            mask        <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= 2'b00;
            out_shift_q <= '0;
            out_last_q  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
